// File: rtl/mem_arbiter.sv
// Byte-wide memory bus arbiter: the store/load buffer gets single-cycle byte grants at IDLE,
// and instruction fetches are serialised into four byte reads followed by a one-cycle ready pulse.
module mem_arbiter #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000,
  parameter int          IO_SPAN = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        control_hazard,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        slb_req,
  input  logic [31:0] slb_addr,
  input  logic        slb_wr,
  input  logic [7:0]  slb_dout,
  output logic        slb_grant,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic [7:0]  mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        ready_q, ready_d;

  logic in_io, io_blk, grant, start;

  assign in_io  = (slb_addr >= IO_BASE) && (slb_addr < IO_BASE + 32'(IO_SPAN));
  assign io_blk = slb_wr & in_io & io_buffer_full;
  assign grant  = rdy_in & (state_q == S_IDLE) & slb_req & ~control_hazard & ~io_blk;
  // A pending if_ready pulse blocks the still-asserted request from restarting a fetch.
  assign start  = rdy_in & (state_q == S_IDLE) & ~grant & if_req & ~ready_q & ~control_hazard;

  assign slb_grant = grant;
  assign if_ready  = ready_q & ~control_hazard;
  assign if_data   = data_q;

  always_comb begin
    mem_a    = 32'h0;
    mem_wr   = 1'b0;
    mem_dout = 8'h0;
    if (grant) begin
      mem_a    = slb_addr;
      mem_wr   = slb_wr;
      mem_dout = slb_dout;
    end else if (state_q == S_FETCH) begin
      mem_a = addr_q + {30'b0, k_q};
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ready_d = ready_q;
    if (rdy_in) begin
      if (control_hazard) begin
        state_d = S_IDLE;
        k_d     = 2'd0;
        ready_d = 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            ready_d = 1'b0;
            if (start) begin
              addr_d  = if_addr;
              state_d = S_FETCH;
              k_d     = 2'd0;
            end
          end
          S_FETCH: begin
            // mem_din carries the byte addressed in the previous cycle
            case (k_q)
              2'd1:    data_d[7:0]   = mem_din;
              2'd2:    data_d[15:8]  = mem_din;
              2'd3:    data_d[23:16] = mem_din;
              default: ;
            endcase
            if (k_q == 2'd3) begin
              state_d = S_FLUSH;
              k_d     = 2'd0;
            end else begin
              k_d = k_q + 2'd1;
            end
          end
          S_FLUSH: begin
            data_d[31:24] = mem_din;
            state_d       = S_IDLE;
            ready_d       = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

endmodule
